mac_array_seq: RTL and testbench
================================

Name: mac_array_seq

Overview:
- Parametrised, time-multiplexed successor to the fixed 4-input/2-output GNN MAC stage.
- Accepts one vector of N_IN ReLU activations plus an N_IN x N_OUT weight matrix via a valid/ready handshake.
- Accumulates one input index per cycle into N_OUT parallel accumulators, then presents saturated N_OUT results with a valid/ready output handshake.
- Sits between a ReLU stage and the next layer / readout logic.

Parameters:
- N_IN, 4, activations per vector (>=2).
- N_OUT, 2, output channels (>=1).
- IN_W, 15, signed activation width.
- W_W, 5, signed weight width.
- OUT_W, 21, signed output width.
- SAT, 1, 1 = saturate to OUT_W; 0 = wrap (keep low OUT_W bits).

Ports:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  activation vector and weights are valid.
- in_ready  output  1  block can accept a vector this cycle.
- x_in  input  N_IN*IN_W  packed signed activations; index k at bits [k*IN_W +: IN_W].
- w_in  input  N_IN*N_OUT*W_W  packed signed weights; w[k][j] at bits [(k*N_OUT+j)*W_W +: W_W].
- out_valid  output  1  results valid.
- out_ready  input  1  downstream consumes results.
- out  output  N_OUT*OUT_W  packed signed results; channel j at bits [j*OUT_W +: OUT_W].
- out_sat  output  N_OUT  per-channel flag: result was clipped (always 0 when SAT=0).

Behaviour:
- Internal accumulator width ACC_W = IN_W + W_W + clog2(N_IN); full precision, never overflows internally.
- States:
  - IDLE: in_ready=1.
    - Accept = in_valid & in_ready. On accept: latch x_in and w_in, clear accumulators, k=0, go CALC.
    - Inputs need not stay stable after the accept edge.
  - CALC: in_ready=0.
    - Each edge: acc[j] += x[k]*w[k][j] for all j (signed); k++.
    - On the edge with k==N_IN-1: register the final value into out/out_sat, set out_valid=1, go DONE.
  - DONE: out, out_sat and out_valid are held stable until out_ready=1.
    - in_ready = out_ready (combinational) in DONE.
    - Edge with out_ready=1 and in_valid=0: out_valid←0, go IDLE.
    - Edge with out_ready=1 and in_valid=1: output consumed and new vector accepted in the same edge; out_valid←0, go CALC. This gives back-to-back operation.
- Latency: out_valid rises exactly N_IN rising edges after the accept edge.
- Throughput: one vector per N_IN+1 cycles when out_ready is held high.
- Output rule, SAT=1: acc > 2^(OUT_W-1)-1 gives max and out_sat[j]=1; acc < -2^(OUT_W-1) gives min and out_sat[j]=1; otherwise acc with out_sat[j]=0.
- Output rule, SAT=0: out = acc[OUT_W-1:0], out_sat=0.
- out holds its last value while IDLE/CALC; it changes only when out_valid rises.
- in_valid while in_ready=0 is ignored; the upstream must hold it.
- Reset, asynchronous, any state including mid-CALC:
  - state=IDLE, k=0, accumulators=0, out=0, out_sat=0, out_valid=0.
  - in_ready=1 from the first cycle after rst deasserts.
  - Any partial result is discarded.
- The valid/ready signals (in_valid, in_ready, out_valid, out_ready) must never be X after reset.

Test Plan:
- Basic, defaults:
  - Stimulus: x=(100,200,-50,7); w[.][0]=(1,2,3,4), w[.][1]=(-1,-1,-1,-1).
  - Response: out0=378, out1=-257, out_sat=00; out_valid exactly 4 edges after accept.
- Saturation, SAT=1:
  - Stimulus: x all -16384, w all -16.
  - Response: both channels 1048575, out_sat=11.
  - Stimulus: x all 16383, w all -16.
  - Response: both channels -1048512 unsaturated, out_sat=00.
- Wrap, SAT=0:
  - Stimulus: same all -16384 / -16 vector.
  - Response: both channels -1048576 (1048576 modulo 2^21), out_sat=00.
- Back-pressure:
  - Stimulus: hold out_ready=0 for 10 cycles after out_valid; toggle x_in/in_valid meanwhile.
  - Response: out stable, in_ready=0; first vector result unaffected.
  - Stimulus: then out_ready=1 together with in_valid=1.
  - Response: next vector accepted the same edge; its result appears 4 edges later.
- Reset mid-operation:
  - Stimulus: assert rst at CALC k=2, release.
  - Response: out_valid=0, out=0, in_ready=1 immediately; the next vector (all x=1, all w=1) yields out0=out1=4.
- Parametrisation:
  - Stimulus: N_IN=8, N_OUT=3, random vectors.
  - Response: latency 8 edges; results match a full-precision golden model plus clip.

Source files
------------

// File: rtl/mac_array_seq.sv
`default_nettype none
// ============================================================================
// Module   : mac_array_seq
// Brief    : Time-multiplexed multiply-accumulate stage. Accepts one vector of
//            N_IN signed activations and an N_IN x N_OUT signed weight matrix,
//            accumulates one input index per cycle into N_OUT full-precision
//            accumulators, then presents saturated (or wrapped) results
//            behind a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module mac_array_seq #(
  parameter int N_IN  = 4,   // activations per vector (>= 2)
  parameter int N_OUT = 2,   // output channels (>= 1)
  parameter int IN_W  = 15,  // signed activation width
  parameter int W_W   = 5,   // signed weight width
  parameter int OUT_W = 21,  // signed output width
  parameter int SAT   = 1    // 1 = clip to OUT_W, 0 = keep low OUT_W bits
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_IN*IN_W-1:0]         x_in,
  input  logic [N_IN*N_OUT*W_W-1:0]    w_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N_OUT*OUT_W-1:0]       out,
  output logic [N_OUT-1:0]             out_sat
);

  // Accumulator is wide enough to hold the sum of N_IN full products.
  localparam int ACC_W = IN_W + W_W + $clog2(N_IN);
  localparam int K_W   = $clog2(N_IN);

  localparam logic [K_W-1:0] K_LAST = K_W'(N_IN - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]                      r_state;
  logic [K_W-1:0]                  r_k;
  logic [N_IN*IN_W-1:0]            r_x;
  logic [N_IN*N_OUT*W_W-1:0]       r_w;
  logic signed [ACC_W-1:0]         r_acc [N_OUT];
  logic [N_OUT*OUT_W-1:0]          r_out;
  logic [N_OUT-1:0]                r_out_sat;
  logic                            r_out_valid;

  logic                            w_accept;
  logic                            w_last;
  logic signed [IN_W-1:0]          w_x_cur;
  logic signed [ACC_W-1:0]         w_x_ext;
  logic signed [ACC_W-1:0]         w_sum [N_OUT];
  logic [N_OUT*OUT_W-1:0]          w_res;
  logic [N_OUT-1:0]                w_res_sat;

  // A new vector can enter when idle, or when the held result is being
  // consumed in this very cycle (back-to-back operation).
  assign in_ready = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
  assign w_accept = in_valid & in_ready;
  assign w_last   = (r_state == S_CALC) && (r_k == K_LAST);

  // Activation selected by the step counter, sign-extended to full width.
  assign w_x_cur = r_x[r_k*IN_W +: IN_W];
  assign w_x_ext = ACC_W'(w_x_cur);

  // Per-channel product, running sum and output conversion.
  for (genvar j = 0; j < N_OUT; j++) begin : g_ch
    logic signed [W_W-1:0]   w_wt_cur;
    logic signed [ACC_W-1:0] w_wt_ext;

    assign w_wt_cur = r_w[(r_k*N_OUT + j)*W_W +: W_W];
    assign w_wt_ext = ACC_W'(w_wt_cur);
    assign w_sum[j] = r_acc[j] + w_x_ext * w_wt_ext;

    if (ACC_W > OUT_W) begin : g_narrow
      if (SAT != 0) begin : g_sat
        // Value fits OUT_W only when every bit above the output sign bit
        // agrees with it; otherwise clip towards the accumulator's sign.
        logic [ACC_W-OUT_W:0] w_top;
        logic                 w_ovf;

        assign w_top = w_sum[j][ACC_W-1:OUT_W-1];
        assign w_ovf = ~((&w_top) | (~|w_top));
        assign w_res[j*OUT_W +: OUT_W] = w_ovf ?
            {w_sum[j][ACC_W-1], {(OUT_W-1){~w_sum[j][ACC_W-1]}}} :
            w_sum[j][OUT_W-1:0];
        assign w_res_sat[j] = w_ovf;
      end else begin : g_wrap
        assign w_res[j*OUT_W +: OUT_W] = w_sum[j][OUT_W-1:0];
        assign w_res_sat[j]            = 1'b0;
      end
    end else begin : g_wide
      // Output is at least as wide as the accumulator: nothing can clip.
      assign w_res[j*OUT_W +: OUT_W] = OUT_W'(w_sum[j]);
      assign w_res_sat[j]            = 1'b0;
    end
  end

  // Control: IDLE -> CALC on accept, CALC -> DONE after N_IN steps,
  // DONE -> IDLE/CALC when the downstream takes the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_CALC;
            r_k     <= '0;
          end
        end
        S_CALC: begin
          r_k <= r_k + K_W'(1);
          if (w_last) begin
            r_k         <= '0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_k         <= '0;
            r_state     <= in_valid ? S_CALC : S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_k         <= '0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Datapath: capture operands on accept, accumulate during CALC,
  // register converted results on the final step only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x       <= '0;
      r_w       <= '0;
      r_out     <= '0;
      r_out_sat <= '0;
      for (int j = 0; j < N_OUT; j++) begin
        r_acc[j] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_x <= x_in;
        r_w <= w_in;
        for (int j = 0; j < N_OUT; j++) begin
          r_acc[j] <= '0;
        end
      end else if (r_state == S_CALC) begin
        for (int j = 0; j < N_OUT; j++) begin
          r_acc[j] <= w_sum[j];
        end
        if (w_last) begin
          r_out     <= w_res;
          r_out_sat <= w_res_sat;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign out_sat   = r_out_sat;

endmodule
`default_nettype wire

// File: tb/tb_mac_array_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_array_seq
// Brief    : Scoreboard bench for mac_array_seq. Three instances share one
//            stimulus stream: defaults with clipping, defaults with wrapping,
//            and an 8-input / 3-output clipping variant.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_array_seq;

  localparam int IN_W    = 15;
  localparam int W_W     = 5;
  localparam int OUT_W   = 21;
  localparam int NINST   = 3;
  localparam int MAX_IN  = 8;
  localparam int MAX_OUT = 3;

  typedef struct packed {
    logic [MAX_OUT*OUT_W-1:0] v;
    logic [MAX_OUT-1:0]       s;
    int                       cyc;
  } exp_t;

  logic clk;
  logic rst;
  logic in_valid;
  logic out_ready;
  int   xs [MAX_IN];
  int   ws [MAX_IN][MAX_OUT];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   rand_on  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: exact dot product per channel, then clip or keep low bits.
  function automatic exp_t model_vec(input int ni, input int no, input bit sat, input int cyc);
    exp_t   e;
    longint acc;
    longint lim;
    e   = '0;
    lim = longint'(1) <<< (OUT_W - 1);
    for (int j = 0; j < no; j++) begin
      acc = 0;
      for (int k = 0; k < ni; k++) acc += longint'(xs[k]) * longint'(ws[k][j]);
      if (sat) begin
        if (acc > lim - 1) begin
          acc = lim - 1; e.s[j] = 1'b1;
        end else if (acc < -lim) begin
          acc = -lim;    e.s[j] = 1'b1;
        end
      end
      // Wrap mode: the low OUT_W bits are the result as-is.
      e.v[j*OUT_W +: OUT_W] = acc[OUT_W-1:0];
    end
    e.cyc = cyc;
    return e;
  endfunction

  function automatic int rnd_x();
    int r;
    r = int'($urandom_range(0, 7));
    if (r == 0) return -16384;
    if (r == 1) return 16383;
    return int'($urandom_range(0, 32767)) - 16384;
  endfunction

  function automatic int rnd_w();
    int r;
    r = int'($urandom_range(0, 5));
    if (r == 0) return -16;
    if (r == 1) return 15;
    return int'($urandom_range(0, 31)) - 16;
  endfunction

  for (genvar g = 0; g < NINST; g++) begin : g_inst
    localparam int NI   = (g == 2) ? 8 : 4;
    localparam int NO   = (g == 2) ? 3 : 2;
    localparam int SATP = (g == 1) ? 0 : 1;

    logic                 in_ready;
    logic                 out_valid;
    logic [NI*IN_W-1:0]   x_in;
    logic [NI*NO*W_W-1:0] w_in;
    logic [NO*OUT_W-1:0]  out;
    logic [NO-1:0]        out_sat;

    exp_t q[$];
    int   busy = 0;
    bit   done = 0;
    int   cyc  = 0;
    int   pend = 0;

    always_comb begin
      x_in = '0;
      w_in = '0;
      for (int k = 0; k < NI; k++) begin
        x_in[k*IN_W +: IN_W] = xs[k][IN_W-1:0];
        for (int j = 0; j < NO; j++) w_in[(k*NO+j)*W_W +: W_W] = ws[k][j][W_W-1:0];
      end
    end

    mac_array_seq #(
      .N_IN(NI), .N_OUT(NO), .IN_W(IN_W), .W_W(W_W), .OUT_W(OUT_W), .SAT(SATP)
    ) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .x_in(x_in), .w_in(w_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .out(out), .out_sat(out_sat)
    );

    // Transaction-level model: busy for NI edges after an accept, then the
    // result is held until the downstream takes it.
    initial begin
      forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
          busy = 0; done = 0; q.delete();
        end else begin
          cyc++;
          if (busy > 0) begin
            busy--;
            if (busy == 0) done = 1;
          end else begin
            if (done && out_ready) done = 0;
            if (!done && in_valid) begin
              busy = NI;
              q.push_back(model_vec(NI, NO, SATP != 0, cyc));
            end
          end
        end
        pend = q.size();
      end
    end

    // Monitor: handshake each cycle, result on presentation, hold otherwise.
    initial begin
      bit                  pres;
      logic [NO*OUT_W-1:0] hold;
      logic [NO-1:0]       hold_s;
      exp_t                e;
      string               tag;
      pres = 0; hold = '0; hold_s = '0;
      tag = $sformatf("i%0d", g);
      forever begin
        @(negedge clk);
        if (rst) begin
          pres = 0; hold = '0; hold_s = '0;
        end else begin
          check({tag, "_hs_known"}, longint'($isunknown({in_ready, out_valid})), 0);
          check({tag, "_in_ready"}, longint'(in_ready),
                longint'((!done && busy == 0) || (done && out_ready)));
          check({tag, "_out_valid"}, longint'(out_valid), longint'(done));
          if (out_valid && !pres) begin
            if (q.size() == 0) begin
              check({tag, "_unexpected_out"}, 1, 0);
            end else begin
              e = q.pop_front();
              check({tag, "_latency"}, cyc - e.cyc, NI);
              for (int j = 0; j < NO; j++) begin
                check($sformatf("%s_out%0d", tag, j),
                      longint'($signed(out[j*OUT_W +: OUT_W])),
                      longint'($signed(e.v[j*OUT_W +: OUT_W])));
                check($sformatf("%s_sat%0d", tag, j), longint'(out_sat[j]), longint'(e.s[j]));
              end
            end
            pres = 1; hold = out; hold_s = out_sat;
          end else begin
            check({tag, "_out_hold"}, longint'(out), longint'(hold));
            check({tag, "_sat_hold"}, longint'(out_sat), longint'(hold_s));
          end
          if (out_valid && out_ready) pres = 0;
        end
      end
    end
  end

  function automatic longint o_of(input int inst, input int j);
    if (inst == 0) return longint'($signed(g_inst[0].out[j*OUT_W +: OUT_W]));
    return longint'($signed(g_inst[1].out[j*OUT_W +: OUT_W]));
  endfunction

  task automatic fill_rand();
    for (int k = 0; k < MAX_IN; k++) begin
      xs[k] = rnd_x();
      for (int j = 0; j < MAX_OUT; j++) ws[k][j] = rnd_w();
    end
  endtask

  task automatic fill_const(input int xv, input int wv);
    for (int k = 0; k < MAX_IN; k++) begin
      xs[k] = xv;
      for (int j = 0; j < MAX_OUT; j++) ws[k][j] = wv;
    end
  endtask

  // Hold in_valid until instance 0 accepts; waits counts refused cycles.
  task automatic send0(output int waits);
    bit ok;
    ok = 0; waits = 0; in_valid = 1'b1;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (g_inst[0].in_ready) ok = 1; else waits++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("accept_timeout", longint'(ok), 1);
  endtask

  task automatic wait_valid0(input string name);
    bit ok;
    ok = 0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (g_inst[0].out_valid) ok = 1;
    end
    check({name, "_valid_timeout"}, longint'(ok), 1);
  endtask

  // Random back-pressure during the random phase.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_on) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    int waits;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    fill_const(0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_in_ready", longint'(g_inst[0].in_ready), 1);
    check("rst_out_valid", longint'(g_inst[0].out_valid), 0);
    check("rst_out0", o_of(0, 0), 0);

    // Basic vector.
    @(posedge clk); #1;
    fill_rand();
    xs[0] = 100; xs[1] = 200; xs[2] = -50; xs[3] = 7;
    for (int k = 0; k < 4; k++) begin ws[k][0] = k + 1; ws[k][1] = -1; end
    send0(waits);
    wait_valid0("basic");
    check("basic_out0", o_of(0, 0), 378);
    check("basic_out1", o_of(0, 1), -257);
    check("basic_sat", longint'(g_inst[0].out_sat), 0);

    // Positive overflow: clipped by instance 0, wrapped by instance 1.
    @(posedge clk); #1;
    fill_const(-16384, -16);
    send0(waits);
    wait_valid0("satpos");
    check("satpos_out0", o_of(0, 0), 1048575);
    check("satpos_out1", o_of(0, 1), 1048575);
    check("satpos_sat", longint'(g_inst[0].out_sat), 3);
    check("wrap_out0", o_of(1, 0), -1048576);
    check("wrap_out1", o_of(1, 1), -1048576);
    check("wrap_sat", longint'(g_inst[1].out_sat), 0);

    // Large negative that still fits.
    @(posedge clk); #1;
    fill_const(16383, -16);
    send0(waits);
    wait_valid0("negfit");
    check("negfit_out0", o_of(0, 0), -1048512);
    check("negfit_sat", longint'(g_inst[0].out_sat), 0);
    check("negfit_wrap", o_of(1, 1), -1048512);

    // Back-pressure: hold the result for 10 cycles while inputs churn.
    @(posedge clk); #1;
    out_ready = 1'b0;
    fill_rand();
    xs[0] = 1000; xs[1] = -2000; xs[2] = 3000; xs[3] = -4000;
    ws[0][0] = 5;   ws[1][0] = 6;  ws[2][0] = 7;   ws[3][0] = 8;
    ws[0][1] = -16; ws[1][1] = 15; ws[2][1] = -16; ws[3][1] = 15;
    send0(waits);
    wait_valid0("bp");
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < MAX_IN; k++) xs[k] = rnd_x();
      in_valid = ($urandom_range(0, 1) != 0);
      @(negedge clk);
      check("bp_in_ready", longint'(g_inst[0].in_ready), 0);
      check("bp_out0", o_of(0, 0), -18000);
      check("bp_out1", o_of(0, 1), -154000);
    end
    @(posedge clk); #1;
    fill_const(2, 1);
    for (int k = 0; k < MAX_IN; k++) ws[k][1] = -2;
    out_ready = 1'b1;
    send0(waits);
    check("b2b_same_edge", waits, 0);
    wait_valid0("b2b");
    check("b2b_out0", o_of(0, 0), 8);
    check("b2b_out1", o_of(0, 1), -16);

    // Reset in the middle of a calculation.
    @(posedge clk); #1;
    fill_rand();
    send0(waits);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_out_valid", longint'(g_inst[0].out_valid), 0);
    check("mid_rst_in_ready", longint'(g_inst[0].in_ready), 1);
    check("mid_rst_out0", o_of(0, 0), 0);
    check("mid_rst_out1", o_of(0, 1), 0);
    @(posedge clk); #1;
    fill_const(1, 1);
    send0(waits);
    wait_valid0("post_rst");
    check("post_rst_out0", o_of(0, 0), 4);
    check("post_rst_out1", o_of(0, 1), 4);

    // Random vectors with random back-pressure and idle gaps.
    @(posedge clk); #1;
    rand_on = 1'b1;
    for (int n = 0; n < 40; n++) begin
      fill_rand();
      send0(waits);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
    end
    rand_on = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("drain_i0", g_inst[0].pend, 0);
    check("drain_i1", g_inst[1].pend, 0);
    check("drain_i2", g_inst[2].pend, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
